// File: rtl/conv_1x1_accum_pkg.sv
// conv_1x1 shared parameter header: default geometry, counter widths, fp32 word view.
package conv_1x1_accum_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int IMAGE_WIDTH_DEF     = 16;
  localparam int IMAGE_HEIGHT_DEF    = 16;
  localparam int CHANNEL_NUM_IN_DEF  = 256;
  localparam int CHANNEL_NUM_OUT_DEF = 512;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IMAGE_SIZE_DEF = IMAGE_WIDTH_DEF * IMAGE_HEIGHT_DEF;
  localparam int PIX_W_DEF      = cnt_w(IMAGE_SIZE_DEF);
  localparam int CH_W_DEF       = cnt_w(CHANNEL_NUM_IN_DEF);
  localparam int OC_W_DEF       = cnt_w(CHANNEL_NUM_OUT_DEF);

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/conv_1x1_accum_fp_add.sv
// Combinational binary32 adder: RNE, flush-to-zero, +0 for zero sums,
// NaN/Inf propagation.
module fp_add
  import conv_1x1_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  fp32_t fa, fb, x, z;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [7:0] d;
  logic [26:0] mx, mz, sh, n;
  logic stk, lz_done, rup;
  logic [27:0] s;
  logic [4:0] lz;
  logic signed [9:0] e;
  logic [24:0] r;

  assign fa = a;
  assign fb = b;

  always_comb begin
    a_zero = fa.exp == 8'h00;
    b_zero = fb.exp == 8'h00;
    a_inf = fa.exp == 8'hFF && fa.frac == '0;
    b_inf = fb.exp == 8'hFF && fb.frac == '0;
    a_nan = fa.exp == 8'hFF && fa.frac != '0;
    b_nan = fb.exp == 8'hFF && fb.frac != '0;
    swap = {fb.exp, fb.frac} > {fa.exp, fa.frac};
    x = swap ? fb : fa;
    z = swap ? fa : fb;
    d = x.exp - z.exp;
    mx = {1'b1, x.frac, 3'b000};
    mz = {1'b1, z.frac, 3'b000};
    sh = '0;
    stk = 1'b1;
    if (d < 8'd27) begin
      sh = mz >> d;
      stk = |(mz & ((27'd1 << d) - 27'd1));
    end
    sh[0] = sh[0] | stk;
    if (x.sign == z.sign) s = {1'b0, mx} + {1'b0, sh};
    else                  s = {1'b0, mx} - {1'b0, sh};
    e = {2'b00, x.exp};
    lz = '0;
    lz_done = 1'b0;
    if (s[27]) begin
      n = s[27:1];
      n[0] = n[0] | s[0];
      e = e + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!lz_done) begin
          if (s[i]) lz_done = 1'b1;
          else      lz = lz + 5'd1;
        end
      end
      n = s[26:0] << lz;
      e = e - 10'(lz);
    end
    // guard = n[2], round|sticky = n[1:0], lsb = n[3]
    rup = n[2] & ((|n[1:0]) | n[3]);
    r = {1'b0, n[26:3]} + 25'(rup);
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (a_nan || b_nan)
      y = a_nan ? (a | FP_QNAN) : (b | FP_QNAN);
    else if (a_inf && b_inf && fa.sign != fb.sign)
      y = FP_QNAN;
    else if (a_inf)
      y = a;
    else if (b_inf)
      y = b;
    else if (a_zero && b_zero)
      y = '0;
    else if (a_zero)
      y = b;
    else if (b_zero)
      y = a;
    else if (s == '0)
      y = '0;
    else if (e >= 10'sd255)
      y = {x.sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      y = {x.sign, 31'd0};
    else
      y = {x.sign, e[7:0], r[22:0]};
  end

endmodule

// File: rtl/conv_1x1_accum.sv
// Channel accumulator behind the 1x1 conv multiplier.
// Optional ReLU on the output: define CONV_1X1_ACCUM_RELU_EN.
module conv_1x1_accum
  import conv_1x1_accum_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int IMAGE_WIDTH     = IMAGE_WIDTH_DEF,
  parameter int IMAGE_HEIGHT    = IMAGE_HEIGHT_DEF,
  parameter int CHANNEL_NUM_IN  = CHANNEL_NUM_IN_DEF,
  parameter int CHANNEL_NUM_OUT = CHANNEL_NUM_OUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PIX_W = cnt_w(IMAGE_SIZE);
  localparam int CH_W = cnt_w(CHANNEL_NUM_IN);
  localparam int OC_W = cnt_w(CHANNEL_NUM_OUT);

  logic [PIX_W-1:0] pix_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic [OC_W-1:0] oc_cnt;
  logic [DATA_WIDTH-1:0] psum [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] rd, sum, out_val, out_fn;
  logic pix_last, ch_first, ch_last, oc_last;

  assign pix_last = pix_cnt == PIX_W'(IMAGE_SIZE - 1);
  assign ch_first = ch_cnt == '0;
  assign ch_last = ch_cnt == CH_W'(CHANNEL_NUM_IN - 1);
  assign oc_last = oc_cnt == OC_W'(CHANNEL_NUM_OUT - 1);
  assign rd = psum[pix_cnt];

  fp_add #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a (rd),
    .b (pxl_in),
    .y (sum)
  );

  // in-channel 0 seeds the slot, so stale data never needs clearing
  assign out_val = ch_first ? pxl_in : sum;

`ifdef CONV_1X1_ACCUM_RELU_EN
  assign out_fn = out_val[DATA_WIDTH-1] ? '0 : out_val;
`else
  assign out_fn = out_val;
`endif

  always_ff @(posedge clk) begin
    if (reset && valid_in && !ch_last)
      psum[pix_cnt] <= out_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_cnt <= '0;
      ch_cnt <= '0;
      oc_cnt <= '0;
    end else if (valid_in) begin
      if (!pix_last) begin
        pix_cnt <= pix_cnt + 1'b1;
      end else begin
        pix_cnt <= '0;
        if (!ch_last) begin
          ch_cnt <= ch_cnt + 1'b1;
        end else begin
          ch_cnt <= '0;
          oc_cnt <= oc_last ? '0 : oc_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pxl_out <= '0;
      valid_out <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out <= valid_in && ch_last;
      frame_done <= valid_in && ch_last && pix_last && oc_last;
      if (valid_in && ch_last)
        pxl_out <= out_fn;
    end
  end

endmodule

// File: tb/tb_conv_1x1_accum.sv
// Scoreboard bench for conv_1x1_accum, 2x1 image, 3 in / 2 out channels.
module tb_conv_1x1_accum;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid_in = 1'b0;
  logic [31:0] pxl_in = '0;
  logic [31:0] pxl_out;
  logic valid_out;
  logic frame_done;

  conv_1x1_accum #(
    .DATA_WIDTH(32),
    .IMAGE_WIDTH(2),
    .IMAGE_HEIGHT(1),
    .CHANNEL_NUM_IN(3),
    .CHANNEL_NUM_OUT(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic done;
    int cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_out = 0;
  int n_done = 0;
  logic [31:0] frames [3][12];
  logic [31:0] gold [3][4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && valid_out) begin
      exp_t e;
      n_out++;
      if (frame_done) n_done++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_out got pxl_out=%h want none", pxl_out);
      end else begin
        e = q.pop_front();
        checks += 2;
        if (pxl_out !== e.d) begin
          failures++;
          $display("FAIL pxl_out got %h want %h", pxl_out, e.d);
        end
        if (frame_done !== e.done) begin
          failures++;
          $display("FAIL frame_done got %b want %b", frame_done, e.done);
        end
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL latency got cycle %0d want %0d", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef CONV_1X1_ACCUM_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit gen, input bit done,
                      input logic [31:0] g);
    exp_t e;
    valid_in = 1'b1;
    pxl_in = d;
    if (gen) begin
      e.d = g;
      e.done = done;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input bit gaps);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      bit last_ch;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      last_ch = ((i / 2) % 3) == 2;
      send(frames[f][i], last_ch, i == 11, relu(gold[f][k]));
      if (last_ch) k++;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d pending want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_counts(input string name, input int o0, input int d0,
                              input int want_o, input int want_d);
    checks += 2;
    if (n_out - o0 != want_o) begin
      failures++;
      $display("FAIL %s_outputs got %0d want %0d", name, n_out - o0, want_o);
    end
    if (n_done - d0 != want_d) begin
      failures++;
      $display("FAIL %s_frame_done got %0d want %0d", name, n_done - d0, want_d);
    end
  endtask

  task automatic check_idle(input string name);
    checks += 3;
    if (pxl_out !== 32'h0) begin
      failures++;
      $display("FAIL %s_pxl_out got %h want 00000000", name, pxl_out);
    end
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_out got %b want 0", name, valid_out);
    end
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_frame_done got %b want 0", name, frame_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_in = 1'b1;
    pxl_in = 32'h3F80_0000;
    repeat (3) begin
      tick();
      check_idle("reset");
    end
    valid_in = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_sum();
    int o0 = n_out, d0 = n_done;
    send_frame(0, 12, 1'b0);
    drain("basic");
    check_counts("basic", o0, d0, 4, 1);
  endtask

  task automatic test_gaps();
    int o0 = n_out, d0 = n_done;
    send_frame(0, 12, 1'b1);
    drain("gaps");
    check_counts("gaps", o0, d0, 4, 1);
  endtask

  task automatic test_sign_relu();
    int o0 = n_out, d0 = n_done;
    send_frame(1, 12, 1'b0);
    drain("sign");
    check_counts("sign", o0, d0, 4, 1);
  endtask

  task automatic test_reset_mid_frame();
    int o0 = n_out, d0 = n_done;
    send_frame(0, 5, 1'b0);
    drain("partial");
    reset = 1'b0;
    valid_in = 1'b1;
    pxl_in = 32'h4100_0000;
    repeat (2) begin
      tick();
      check_idle("mid_reset");
    end
    valid_in = 1'b0;
    reset = 1'b1;
    tick();
    send_frame(0, 12, 1'b0);
    drain("after_reset");
    check_counts("reset_mid", o0, d0, 5, 1);
  endtask

  task automatic test_back_to_back_frames();
    int o0 = n_out, d0 = n_done;
    send_frame(1, 12, 1'b0);
    send_frame(2, 12, 1'b0);
    drain("b2b");
    check_counts("b2b", o0, d0, 8, 2);
  endtask

  initial begin
    frames[0] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000,
                  32'h40400000, 32'h3F800000, 32'h40800000, 32'h3F000000,
                  32'h40A00000, 32'h3F000000, 32'hBF800000, 32'h40000000};
    gold[0] = '{32'h40C00000, 32'h40C00000, 32'h41000000, 32'h40400000};
    frames[1] = '{32'h41200000, 32'h3E800000, 32'h41200000, 32'h3E800000,
                  32'h41200000, 32'h3E800000, 32'hBF800000, 32'h00000000,
                  32'hBF800000, 32'h00000000, 32'h3F800000, 32'h00000000};
    gold[1] = '{32'h41F00000, 32'h3F400000, 32'hBF800000, 32'h00000000};
    frames[2] = '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h34000000,
                  32'h33800000, 32'h33800000, 32'h40400000, 32'h7F800000,
                  32'hC0400000, 32'h3F800000, 32'h3F000000, 32'h3F800000};
    gold[2] = '{32'h3F800000, 32'h3F800002, 32'h3F000000, 32'h7F800000};
    test_reset();
    test_basic_sum();
    test_gaps();
    test_sign_relu();
    test_reset_mid_frame();
    test_back_to_back_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
